voice_mixer: RTL
================

Name: voice_mixer

Overview:
- Sits directly downstream of the FM operator core.
- Sums the per-voice carrier subsamples the core emits each sample period into one mixed sample, applies master volume and saturates to 16 bits.
- Queues finished samples in a small FIFO for the output serializer (I2S/DAC) through a valid/ready handshake.
- Drops the first, partial frame after reset so that only whole frames are ever emitted.

Parameters:
- DEPTH, 4: FIFO depth in samples; power of two, at least 2.
- SHIFT, 7: right arithmetic shift applied after the volume multiply. With SHIFT=7, i_Volume=128 gives unity gain.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Subsample  in  16  signed subsample from the core.
- i_SubsampleReady  in  1  i_Subsample is valid this cycle and must be accumulated.
- i_SampleReady  in  1  last subsample of the frame; may coincide with i_SubsampleReady.
- i_Volume  in  8  unsigned master volume; sampled on the cycle it is used.
- i_ClearOverflow  in  1  clears o_Overflow.
- o_Sample  out  16  signed mixed sample at the FIFO head.
- o_Valid  out  1  o_Sample is valid.
- i_Ready  in  1  downstream accepts o_Sample when o_Valid && i_Ready.
- o_Overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.

Behaviour:
- Reset (async, i_Reset=1): all of the following are cleared immediately.
  - Outputs: o_Sample=0, o_Valid=0, o_Overflow=0.
  - Internal: accumulator=0, pipeline valids=0, FIFO empty, state=SYNC.
- State machine:
  - SYNC: i_SubsampleReady is ignored. On i_SampleReady: clear the accumulator, go to RUN, emit nothing.
  - RUN: i_SubsampleReady adds sign-extended i_Subsample to a 20-bit signed accumulator.
  - RUN, on i_SampleReady (cycle N):
    - Final sum = accumulator + (i_SubsampleReady ? i_Subsample : 0); the same-cycle subsample is included.
    - The final sum is latched into stage-1 and stage-1 valid is set.
    - The accumulator is cleared to 0 at the same edge.
  - i_SampleReady with no subsamples in the frame: emits 0.
- Accumulator arithmetic: 20 bits holds 16 voices of full scale without wrap. Overflow of the accumulator itself is not checked.
- Stage 2 (edge N+1): product = stage1 × {1'b0, i_Volume}, 29-bit signed.
- Stage 3 (edge N+2):
  - Scaling: s = product >>> SHIFT, an arithmetic shift that floors toward −inf.
  - Saturation: clamp s to [−32768, 32767].
  - Push the result into the FIFO.
- Latency: if the FIFO was empty and i_Ready is ignored, o_Valid=1 with the sample on o_Sample from cycle N+3.
- FIFO behaviour:
  - o_Sample and o_Valid are driven from registered/FIFO head state only, never combinationally from the inputs.
  - Push and pop in the same cycle are both honoured. When full with a simultaneous pop, the push succeeds and no overflow is flagged.
  - Push when full without a pop: the new sample is dropped, the FIFO contents are unchanged, and o_Overflow is set at that edge.
- o_Overflow:
  - Stays set until i_ClearOverflow=1.
  - If clear and a new overflow happen on the same edge, set wins.
- Pipeline ordering:
  - Back-to-back frames are accepted every cycle; stages are independent.
  - A new i_SampleReady never stalls; there is no backpressure toward the core.
- Reset mid-operation: any partial accumulation and all queued samples are discarded, and the block returns to SYNC.

Test Plan:
- Reset, then one frame of 16×i_Subsample=1000 with a separate i_SampleReady -> no output (SYNC). Second identical frame, vol=128, i_Ready=1 -> one sample 16000, o_Valid high exactly at N+3.
- 16×30000, vol=128 -> 32767. 16×(−30000) -> −32768. 16×1000, vol=255 -> 31875.
- One subsample of −1, vol=1 -> −1 (floor behaviour). i_SampleReady coinciding with the last subsample of 500 after 15×500 -> 8000 (same-cycle inclusion).
- i_Ready=0 for 6 frames, DEPTH=4 -> 4 samples held in order and o_Overflow=1 after the 5th frame. Drain with i_Ready=1 -> the first 4 values in order, then o_Valid=0. i_ClearOverflow -> 0.
- FIFO full with a pop and push on the same edge -> no overflow, occupancy stays 4, order preserved.
- Assert i_Reset mid-frame and while the FIFO is non-empty -> o_Valid drops immediately, o_Sample=0. The next i_SampleReady emits nothing (SYNC), and the following full frame emits the correct sum.

Source files
------------

// File: rtl/voice_mixer.sv
// Voice mixer: accumulates per-voice subsamples into a frame sum, applies master
// volume with saturation, and queues finished samples in a small output FIFO.
module voice_mixer #(
   parameter int DEPTH = 4,
   parameter int SHIFT = 7
) (
   input  logic               i_Clock,
   input  logic               i_Reset,
   input  logic signed [15:0] i_Subsample,
   input  logic               i_SubsampleReady,
   input  logic               i_SampleReady,
   input  logic        [7:0]  i_Volume,
   input  logic               i_ClearOverflow,
   output logic signed [15:0] o_Sample,
   output logic               o_Valid,
   input  logic               i_Ready,
   output logic               o_Overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic signed [28:0] SAT_HI = 29'sd32767;
   localparam logic signed [28:0] SAT_LO = -29'sd32768;

   typedef enum logic [0:0] {SYNC = 1'b0, RUN = 1'b1} state_t;

   state_t             state_r, next_state_s;
   logic signed [19:0] accum_r, accum_next_s, addend_s, final_sum_s;
   logic               s1_load_s;
   logic signed [19:0] stage1_r;
   logic               s1_valid_r;
   logic signed [28:0] product_s, product_r, scaled_s;
   logic               s2_valid_r;
   logic signed [15:0] sat_s;
   logic        [15:0] mem_r [DEPTH];
   logic     [AW-1:0]  wr_ptr_r, rd_ptr_r;
   logic     [AW:0]    count_r;
   logic               full_s, pop_s, accept_s, ovf_set_s, overflow_r;

   assign addend_s    = i_SubsampleReady ? {{4{i_Subsample[15]}}, i_Subsample} : 20'sd0;
   assign final_sum_s = accum_r + addend_s;

   // Frame sequencing: SYNC discards the partial frame seen after reset.
   always_comb begin
      next_state_s = state_r;
      accum_next_s = accum_r;
      s1_load_s    = 1'b0;
      case (state_r)
         SYNC: begin
            if (i_SampleReady) begin
               next_state_s = RUN;
               accum_next_s = 20'sd0;
            end else begin
               accum_next_s = accum_r;
            end
         end
         RUN: begin
            if (i_SampleReady) begin
               s1_load_s    = 1'b1;
               accum_next_s = 20'sd0;
            end else if (i_SubsampleReady) begin
               accum_next_s = final_sum_s;
            end else begin
               accum_next_s = accum_r;
            end
         end
         default: begin
            next_state_s = SYNC;
            accum_next_s = 20'sd0;
         end
      endcase
   end

   // State, accumulator and stage-1 frame sum.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_r    <= SYNC;
         accum_r    <= 20'sd0;
         stage1_r   <= 20'sd0;
         s1_valid_r <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         accum_r    <= accum_next_s;
         s1_valid_r <= s1_load_s;
         if (s1_load_s) begin
            stage1_r <= final_sum_s;
         end
      end
   end

   assign product_s = $signed({{9{stage1_r[19]}}, stage1_r}) * $signed({21'd0, i_Volume});

   // Stage 2: volume multiply, using the volume present on this cycle.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         product_r  <= 29'sd0;
         s2_valid_r <= 1'b0;
      end else begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            product_r <= product_s;
         end
      end
   end

   assign scaled_s = product_r >>> SHIFT;

   // Stage 3 saturation to the 16-bit output range.
   always_comb begin
      if (scaled_s > SAT_HI) begin
         sat_s = 16'sh7FFF;
      end else if (scaled_s < SAT_LO) begin
         sat_s = 16'sh8000;
      end else begin
         sat_s = scaled_s[15:0];
      end
   end

   assign full_s    = (count_r == (AW+1)'(DEPTH));
   assign pop_s     = (count_r != {(AW+1){1'b0}}) && i_Ready;
   assign accept_s  = s2_valid_r && (!full_s || pop_s);
   assign ovf_set_s = s2_valid_r && full_s && !pop_s;

   // FIFO storage; contents are only visible while the occupancy count says so.
   always_ff @(posedge i_Clock) begin
      if (accept_s) begin
         mem_r[wr_ptr_r] <= sat_s;
      end
   end

   // FIFO pointers, occupancy and sticky overflow (set beats clear).
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         count_r    <= {(AW+1){1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({accept_s, pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end else if (i_ClearOverflow) begin
            overflow_r <= 1'b0;
         end
      end
   end

   assign o_Valid    = (count_r != {(AW+1){1'b0}});
   assign o_Sample   = o_Valid ? $signed(mem_r[rd_ptr_r]) : 16'sd0;
   assign o_Overflow = overflow_r;

endmodule
